// File: rtl/hit_judge_pkg.sv
// Shared types and constants for the block hit judge: swing directions,
// game-state code, FSM states and the verdict record.
package hit_judge_pkg;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_ANY   = 3'd4
    } dir_e;

    localparam logic [1:0] STATE_PLAYING = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_HEAD,
        S_REPORT
    } fsm_e;

    typedef struct packed {
        logic sliced;
        logic bad_cut;
        logic missed;
        logic player_hit;
    } verdict_t;

    // Collapse the raw flags into one exclusive verdict:
    // player_hit > sliced > bad_cut > missed.
    function automatic verdict_t resolve_verdict(input verdict_t raw);
        verdict_t v;
        v = '0;
        if (raw.player_hit)   v.player_hit = 1'b1;
        else if (raw.sliced)  v.sliced     = 1'b1;
        else if (raw.bad_cut) v.bad_cut    = 1'b1;
        else if (raw.missed)  v.missed     = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Block-descriptor handshake and verdict bus between the spawner/scoring
// logic (master) and the hit judge (slave).
interface hit_judge_if #(
    parameter int X_WIDTH = 12,
    parameter int Y_WIDTH = 12,
    parameter int Z_WIDTH = 14
);
    logic               block_valid_in;
    logic               block_ready_out;
    logic [7:0]         block_index_in;
    logic [X_WIDTH-1:0] block_x_in;
    logic [Y_WIDTH-1:0] block_y_in;
    logic [Z_WIDTH-1:0] block_z_in;
    logic               block_color_in;
    logic [2:0]         block_direction_in;
    logic               block_is_obstacle_in;

    logic               result_valid_out;
    logic [7:0]         result_index_out;
    logic               block_sliced_out;
    logic               bad_cut_out;
    logic               block_missed_out;
    logic               player_hit_out;

    modport master (
        output block_valid_in, block_index_in, block_x_in, block_y_in, block_z_in,
               block_color_in, block_direction_in, block_is_obstacle_in,
        input  block_ready_out, result_valid_out, result_index_out,
               block_sliced_out, bad_cut_out, block_missed_out, player_hit_out
    );

    modport slave (
        input  block_valid_in, block_index_in, block_x_in, block_y_in, block_z_in,
               block_color_in, block_direction_in, block_is_obstacle_in,
        output block_ready_out, result_valid_out, result_index_out,
               block_sliced_out, bad_cut_out, block_missed_out, player_hit_out
    );
endinterface

// File: rtl/hit_judge_box_test.sv
// Combinational test of a segment (tip, hilt, midpoint) against a block's
// hit box, plus the swing-direction match for the tip displacement.
module hit_judge_box_test
    import hit_judge_pkg::*;
#(
    parameter int X_WIDTH   = 12,
    parameter int Y_WIDTH   = 12,
    parameter int Z_WIDTH   = 14,
    parameter int HIT_R     = 64,
    parameter int HIT_DZ    = 128,
    parameter int SWING_MIN = 32
) (
    input  logic [X_WIDTH-1:0] i_top_x,
    input  logic [Y_WIDTH-1:0] i_top_y,
    input  logic [Z_WIDTH-1:0] i_top_z,
    input  logic [X_WIDTH-1:0] i_bot_x,
    input  logic [Y_WIDTH-1:0] i_bot_y,
    input  logic [Z_WIDTH-1:0] i_bot_z,
    input  logic [X_WIDTH-1:0] i_blk_x,
    input  logic [Y_WIDTH-1:0] i_blk_y,
    input  logic [Z_WIDTH-1:0] i_blk_z,
    input  logic [X_WIDTH-1:0] i_prev_x,
    input  logic [Y_WIDTH-1:0] i_prev_y,
    input  logic               i_prev_valid,
    input  logic [2:0]         i_direction,
    output logic               o_in_box,
    output logic               o_dir_ok
);

    localparam logic signed [X_WIDTH+1:0] R_X  = (X_WIDTH+2)'(HIT_R);
    localparam logic signed [Y_WIDTH+1:0] R_Y  = (Y_WIDTH+2)'(HIT_R);
    localparam logic signed [Z_WIDTH+1:0] R_Z  = (Z_WIDTH+2)'(HIT_DZ);
    localparam logic signed [X_WIDTH:0]   SW_X = (X_WIDTH+1)'(SWING_MIN);
    localparam logic signed [Y_WIDTH:0]   SW_Y = (Y_WIDTH+1)'(SWING_MIN);

    // Points carried at width+1 so the midpoint sum never wraps.
    logic [X_WIDTH:0] w_px [3];
    logic [Y_WIDTH:0] w_py [3];
    logic [Z_WIDTH:0] w_pz [3];
    logic [2:0]       w_hit;

    assign w_px[0] = {1'b0, i_top_x};
    assign w_py[0] = {1'b0, i_top_y};
    assign w_pz[0] = {1'b0, i_top_z};
    assign w_px[1] = {1'b0, i_bot_x};
    assign w_py[1] = {1'b0, i_bot_y};
    assign w_pz[1] = {1'b0, i_bot_z};
    assign w_px[2] = ({1'b0, i_top_x} + {1'b0, i_bot_x}) >> 1;
    assign w_py[2] = ({1'b0, i_top_y} + {1'b0, i_bot_y}) >> 1;
    assign w_pz[2] = ({1'b0, i_top_z} + {1'b0, i_bot_z}) >> 1;

    for (genvar g = 0; g < 3; g++) begin : g_point
        logic signed [X_WIDTH+1:0] w_dx;
        logic signed [Y_WIDTH+1:0] w_dy;
        logic signed [Z_WIDTH+1:0] w_dz;
        assign w_dx = $signed({1'b0, w_px[g]}) - $signed({2'b00, i_blk_x});
        assign w_dy = $signed({1'b0, w_py[g]}) - $signed({2'b00, i_blk_y});
        assign w_dz = $signed({1'b0, w_pz[g]}) - $signed({2'b00, i_blk_z});
        assign w_hit[g] = (w_dx <= R_X) && (w_dx >= -R_X) &&
                          (w_dy <= R_Y) && (w_dy >= -R_Y) &&
                          (w_dz <= R_Z) && (w_dz >= -R_Z);
    end

    assign o_in_box = |w_hit;

    logic signed [X_WIDTH:0] w_swing_x;
    logic signed [Y_WIDTH:0] w_swing_y;

    assign w_swing_x = $signed({1'b0, i_top_x}) - $signed({1'b0, i_prev_x});
    assign w_swing_y = $signed({1'b0, i_top_y}) - $signed({1'b0, i_prev_y});

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_dir_ok = 1'b1;
        case (i_direction)
            DIR_UP:    o_dir_ok = i_prev_valid && (w_swing_y <= -SW_Y);
            DIR_DOWN:  o_dir_ok = i_prev_valid && (w_swing_y >=  SW_Y);
            DIR_LEFT:  o_dir_ok = i_prev_valid && (w_swing_x <= -SW_X);
            DIR_RIGHT: o_dir_ok = i_prev_valid && (w_swing_x >=  SW_X);
            default:   o_dir_ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/hit_judge.sv
// Per-block hit judge: accepts a block, walks the saber snapshots one per
// cycle (or tests the head for obstacles) and emits one registered verdict.
module hit_judge
    import hit_judge_pkg::*;
#(
    parameter int                  N_SABERS    = 2,
    parameter int                  X_WIDTH     = 12,
    parameter int                  Y_WIDTH     = 12,
    parameter int                  Z_WIDTH     = 14,
    parameter int                  HIT_R       = 64,
    parameter int                  HIT_DZ      = 128,
    parameter int                  MISS_Z      = 16,
    parameter int                  SWING_MIN   = 32,
    parameter logic [N_SABERS-1:0] SABER_COLOR = N_SABERS'(2'b10)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [1:0]                    state_in,
    hit_judge_if.slave                    bus,
    input  logic [N_SABERS*X_WIDTH-1:0]   saber_x_top_in,
    input  logic [N_SABERS*Y_WIDTH-1:0]   saber_y_top_in,
    input  logic [N_SABERS*Z_WIDTH-1:0]   saber_z_top_in,
    input  logic [N_SABERS*X_WIDTH-1:0]   saber_x_bot_in,
    input  logic [N_SABERS*Y_WIDTH-1:0]   saber_y_bot_in,
    input  logic [N_SABERS*Z_WIDTH-1:0]   saber_z_bot_in,
    input  logic                          hand_update_in,
    input  logic [X_WIDTH-1:0]            head_x_in,
    input  logic [Y_WIDTH-1:0]            head_y_in,
    input  logic [Z_WIDTH-1:0]            head_z_in
);

    localparam int IDX_W = (N_SABERS > 1) ? $clog2(N_SABERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SABERS - 1);

    logic [X_WIDTH-1:0] w_top_x [N_SABERS];
    logic [Y_WIDTH-1:0] w_top_y [N_SABERS];
    logic [Z_WIDTH-1:0] w_top_z [N_SABERS];
    logic [X_WIDTH-1:0] w_bot_x [N_SABERS];
    logic [Y_WIDTH-1:0] w_bot_y [N_SABERS];
    logic [Z_WIDTH-1:0] w_bot_z [N_SABERS];

    for (genvar g = 0; g < N_SABERS; g++) begin : g_unpack
        assign w_top_x[g] = saber_x_top_in[g*X_WIDTH +: X_WIDTH];
        assign w_top_y[g] = saber_y_top_in[g*Y_WIDTH +: Y_WIDTH];
        assign w_top_z[g] = saber_z_top_in[g*Z_WIDTH +: Z_WIDTH];
        assign w_bot_x[g] = saber_x_bot_in[g*X_WIDTH +: X_WIDTH];
        assign w_bot_y[g] = saber_y_bot_in[g*Y_WIDTH +: Y_WIDTH];
        assign w_bot_z[g] = saber_z_bot_in[g*Z_WIDTH +: Z_WIDTH];
    end

    fsm_e             r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_playing;
    logic             r_sliced;
    logic             r_bad_cut;
    logic             r_player_hit;
    logic             r_result_valid;
    logic [7:0]       r_result_index;
    verdict_t         r_verdict;

    logic [X_WIDTH-1:0] r_prev_x [N_SABERS];
    logic [Y_WIDTH-1:0] r_prev_y [N_SABERS];
    logic               r_prev_valid;

    logic [7:0]         r_blk_index;
    logic [X_WIDTH-1:0] r_blk_x;
    logic [Y_WIDTH-1:0] r_blk_y;
    logic [Z_WIDTH-1:0] r_blk_z;
    logic               r_blk_color;
    logic [2:0]         r_blk_dir;
    logic               r_blk_obstacle;
    logic [X_WIDTH-1:0] r_snap_top_x [N_SABERS];
    logic [Y_WIDTH-1:0] r_snap_top_y [N_SABERS];
    logic [Z_WIDTH-1:0] r_snap_top_z [N_SABERS];
    logic [X_WIDTH-1:0] r_snap_bot_x [N_SABERS];
    logic [Y_WIDTH-1:0] r_snap_bot_y [N_SABERS];
    logic [Z_WIDTH-1:0] r_snap_bot_z [N_SABERS];
    logic [X_WIDTH-1:0] r_snap_prev_x [N_SABERS];
    logic [Y_WIDTH-1:0] r_snap_prev_y [N_SABERS];
    logic               r_snap_prev_valid;
    logic [X_WIDTH-1:0] r_head_x;
    logic [Y_WIDTH-1:0] r_head_y;
    logic [Z_WIDTH-1:0] r_head_z;

    logic w_accept;
    assign w_accept = bus.block_valid_in && (r_state == S_IDLE);

    // Previous tips track the hand stream regardless of what the FSM is doing.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_prev_x     <= '{default: '0};
            r_prev_y     <= '{default: '0};
            r_prev_valid <= 1'b0;
        end else if (hand_update_in) begin
            r_prev_x     <= w_top_x;
            r_prev_y     <= w_top_y;
            r_prev_valid <= 1'b1;
        end
    end

    // NOTE: snapshot registers are pure data qualified by the FSM, so they carry no reset.
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_blk_index       <= bus.block_index_in;
            r_blk_x           <= bus.block_x_in;
            r_blk_y           <= bus.block_y_in;
            r_blk_z           <= bus.block_z_in;
            r_blk_color       <= bus.block_color_in;
            r_blk_dir         <= bus.block_direction_in;
            r_blk_obstacle    <= bus.block_is_obstacle_in;
            r_snap_top_x      <= w_top_x;
            r_snap_top_y      <= w_top_y;
            r_snap_top_z      <= w_top_z;
            r_snap_bot_x      <= w_bot_x;
            r_snap_bot_y      <= w_bot_y;
            r_snap_bot_z      <= w_bot_z;
            r_snap_prev_x     <= r_prev_x;
            r_snap_prev_y     <= r_prev_y;
            r_snap_prev_valid <= r_prev_valid;
            r_head_x          <= head_x_in;
            r_head_y          <= head_y_in;
            r_head_z          <= head_z_in;
        end
    end

    // The single box tester sees the indexed saber in CHECK and the head in HEAD.
    logic [X_WIDTH-1:0] w_pt_top_x, w_pt_bot_x;
    logic [Y_WIDTH-1:0] w_pt_top_y, w_pt_bot_y;
    logic [Z_WIDTH-1:0] w_pt_top_z, w_pt_bot_z;
    logic               w_in_box;
    logic               w_dir_ok;

    always_comb begin
        w_pt_top_x = r_snap_top_x[r_idx];
        w_pt_top_y = r_snap_top_y[r_idx];
        w_pt_top_z = r_snap_top_z[r_idx];
        w_pt_bot_x = r_snap_bot_x[r_idx];
        w_pt_bot_y = r_snap_bot_y[r_idx];
        w_pt_bot_z = r_snap_bot_z[r_idx];
        if (r_state == S_HEAD) begin
            w_pt_top_x = r_head_x;
            w_pt_top_y = r_head_y;
            w_pt_top_z = r_head_z;
            w_pt_bot_x = r_head_x;
            w_pt_bot_y = r_head_y;
            w_pt_bot_z = r_head_z;
        end
    end

    hit_judge_box_test #(
        .X_WIDTH   (X_WIDTH),
        .Y_WIDTH   (Y_WIDTH),
        .Z_WIDTH   (Z_WIDTH),
        .HIT_R     (HIT_R),
        .HIT_DZ    (HIT_DZ),
        .SWING_MIN (SWING_MIN)
    ) u_box_test (
        .i_top_x      (w_pt_top_x),
        .i_top_y      (w_pt_top_y),
        .i_top_z      (w_pt_top_z),
        .i_bot_x      (w_pt_bot_x),
        .i_bot_y      (w_pt_bot_y),
        .i_bot_z      (w_pt_bot_z),
        .i_blk_x      (r_blk_x),
        .i_blk_y      (r_blk_y),
        .i_blk_z      (r_blk_z),
        .i_prev_x     (r_snap_prev_x[r_idx]),
        .i_prev_y     (r_snap_prev_y[r_idx]),
        .i_prev_valid (r_snap_prev_valid),
        .i_direction  (r_blk_dir),
        .o_in_box     (w_in_box),
        .o_dir_ok     (w_dir_ok)
    );

    verdict_t w_raw;
    always_comb begin
        w_raw            = '0;
        w_raw.player_hit = r_player_hit;
        w_raw.sliced     = r_sliced;
        w_raw.bad_cut    = r_bad_cut;
        w_raw.missed     = r_playing && !r_blk_obstacle && (r_blk_z < Z_WIDTH'(MISS_Z));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_playing      <= 1'b0;
            r_sliced       <= 1'b0;
            r_bad_cut      <= 1'b0;
            r_player_hit   <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_index <= '0;
            r_verdict      <= '0;
        end else begin
            r_result_valid <= 1'b0;
            r_verdict      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx        <= '0;
                        r_sliced     <= 1'b0;
                        r_bad_cut    <= 1'b0;
                        r_player_hit <= 1'b0;
                        r_playing    <= (state_in == STATE_PLAYING);
                        if (state_in != STATE_PLAYING)        r_state <= S_REPORT;
                        else if (bus.block_is_obstacle_in)    r_state <= S_HEAD;
                        else                                  r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_in_box) begin
                        if ((SABER_COLOR[r_idx] == r_blk_color) && w_dir_ok) r_sliced  <= 1'b1;
                        else                                                 r_bad_cut <= 1'b1;
                    end
                    if (r_idx == LAST_IDX) r_state <= S_REPORT;
                    else                   r_idx   <= r_idx + 1'b1;
                end
                S_HEAD: begin
                    r_player_hit <= w_in_box;
                    r_state      <= S_REPORT;
                end
                S_REPORT: begin
                    r_result_valid <= 1'b1;
                    r_result_index <= r_blk_index;
                    r_verdict      <= resolve_verdict(w_raw);
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.block_ready_out  = (r_state == S_IDLE);
    assign bus.result_valid_out = r_result_valid;
    assign bus.result_index_out = r_result_index;
    assign bus.block_sliced_out = r_verdict.sliced;
    assign bus.bad_cut_out      = r_verdict.bad_cut;
    assign bus.block_missed_out = r_verdict.missed;
    assign bus.player_hit_out   = r_verdict.player_hit;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: hand-computed verdicts, latencies and reset behaviour.
module tb_hit_judge;
    import hit_judge_pkg::*;

    localparam int N  = 2;
    localparam int XW = 12;
    localparam int YW = 12;
    localparam int ZW = 14;

    logic            clk;
    logic            rst;
    logic [1:0]      state;
    logic [N*XW-1:0] sx_top, sx_bot;
    logic [N*YW-1:0] sy_top, sy_bot;
    logic [N*ZW-1:0] sz_top, sz_bot;
    logic            hand_update;
    logic [XW-1:0]   head_x;
    logic [YW-1:0]   head_y;
    logic [ZW-1:0]   head_z;

    int n_cmp = 0;
    int n_err = 0;

    hit_judge_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .Z_WIDTH(ZW)) bus ();

    hit_judge #(.N_SABERS(N), .X_WIDTH(XW), .Y_WIDTH(YW), .Z_WIDTH(ZW)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .state_in       (state),
        .bus            (bus),
        .saber_x_top_in (sx_top),
        .saber_y_top_in (sy_top),
        .saber_z_top_in (sz_top),
        .saber_x_bot_in (sx_bot),
        .saber_y_bot_in (sy_bot),
        .saber_z_bot_in (sz_bot),
        .hand_update_in (hand_update),
        .head_x_in      (head_x),
        .head_y_in      (head_y),
        .head_z_in      (head_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_saber(input int i, input int tx, input int ty, input int tz,
                             input int bx, input int by, input int bz);
        sx_top[i*XW +: XW] = XW'(tx);
        sy_top[i*YW +: YW] = YW'(ty);
        sz_top[i*ZW +: ZW] = ZW'(tz);
        sx_bot[i*XW +: XW] = XW'(bx);
        sy_bot[i*YW +: YW] = YW'(by);
        sz_bot[i*ZW +: ZW] = ZW'(bz);
    endtask

    task automatic pulse_hand();
        @(negedge clk);
        hand_update = 1'b1;
        @(negedge clk);
        hand_update = 1'b0;
    endtask

    function automatic logic [3:0] flags();
        return {bus.block_sliced_out, bus.bad_cut_out, bus.block_missed_out, bus.player_hit_out};
    endfunction

    // exp_flags = {sliced, bad_cut, missed, player_hit}
    task automatic run_block(input string tag, input int id, input int x, input int y, input int z,
                             input bit color, input int dir, input bit obs,
                             input int exp_lat, input logic [3:0] exp_flags);
        int         lat;
        logic [3:0] got_flags;
        logic [7:0] got_idx;
        lat       = 0;
        got_flags = '0;
        got_idx   = '0;
        @(negedge clk);
        check({tag, " ready_idle"}, 32'(bus.block_ready_out), 32'd1);
        bus.block_valid_in       = 1'b1;
        bus.block_index_in       = 8'(id);
        bus.block_x_in           = XW'(x);
        bus.block_y_in           = YW'(y);
        bus.block_z_in           = ZW'(z);
        bus.block_color_in       = color;
        bus.block_direction_in   = 3'(dir);
        bus.block_is_obstacle_in = obs;
        @(posedge clk);
        #1 bus.block_valid_in = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, " ready_busy"}, 32'(bus.block_ready_out), 32'd0);
            if (bus.result_valid_out) begin
                lat       = k;
                got_flags = flags();
                got_idx   = bus.result_index_out;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " flags"}, 32'(got_flags), 32'(exp_flags));
        check({tag, " index"}, 32'(got_idx), 32'(id));
        @(negedge clk);
        check({tag, " pulse_end"}, 32'(bus.result_valid_out), 32'd0);
    endtask

    initial begin
        int stray;
        rst         = 1'b1;
        state       = STATE_PLAYING;
        hand_update = 1'b0;
        head_x      = '0;
        head_y      = '0;
        head_z      = '0;
        sx_top = '0; sy_top = '0; sz_top = '0;
        sx_bot = '0; sy_bot = '0; sz_bot = '0;
        bus.block_valid_in       = 1'b0;
        bus.block_index_in       = '0;
        bus.block_x_in           = '0;
        bus.block_y_in           = '0;
        bus.block_z_in           = '0;
        bus.block_color_in       = 1'b0;
        bus.block_direction_in   = '0;
        bus.block_is_obstacle_in = 1'b0;
        set_saber(0, 2000, 2000, 100, 2000, 2000, 100);
        set_saber(1, 500, 300, 100, 500, 500, 100);
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.block_ready_out), 32'd1);
        check("reset valid", 32'(bus.result_valid_out), 32'd0);
        check("reset flags", 32'(flags()), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Swing down by 80 on saber 1 (colour 1).
        pulse_hand();
        set_saber(1, 500, 380, 100, 500, 500, 100);
        run_block("t1_slice",     7, 500, 400, 100, 1'b1, DIR_DOWN, 1'b0, 4, 4'b1000);
        run_block("t2_colour",    8, 500, 400, 100, 1'b0, DIR_DOWN, 1'b0, 4, 4'b0100);
        run_block("box_edge_in",  9, 564, 400, 100, 1'b1, DIR_DOWN, 1'b0, 4, 4'b1000);
        run_block("box_edge_out",10, 565, 400, 100, 1'b1, DIR_DOWN, 1'b0, 4, 4'b0000);

        // Weak swing: prev 370, tip 380 (dy = 10).
        set_saber(1, 500, 370, 100, 500, 500, 100);
        pulse_hand();
        set_saber(1, 500, 380, 100, 500, 500, 100);
        run_block("t3_weak",     11, 500, 400, 100, 1'b1, DIR_DOWN, 1'b0, 4, 4'b0100);
        run_block("t3_any",      12, 500, 400, 100, 1'b1, 4,        1'b0, 4, 4'b1000);
        set_saber(1, 500, 402, 100, 500, 500, 100);
        run_block("swing_eq_min",13, 500, 400, 100, 1'b1, DIR_DOWN, 1'b0, 4, 4'b1000);
        set_saber(1, 500, 401, 100, 500, 500, 100);
        run_block("swing_lt_min",14, 500, 400, 100, 1'b1, DIR_DOWN, 1'b0, 4, 4'b0100);

        // Obstacles against the head.
        head_x = 230; head_y = 180; head_z = 60;
        run_block("t4_head_hit", 20, 200, 200, 50, 1'b0, 4, 1'b1, 3, 4'b0001);
        head_x = 300;
        run_block("t4_head_miss",21, 200, 200, 50, 1'b0, 4, 1'b1, 3, 4'b0000);

        // Notes reaching the player plane with nothing near them.
        run_block("t5_missed",   30, 1000, 1000, 10, 1'b0, 4, 1'b0, 4, 4'b0010);
        run_block("miss_z15",    31, 1000, 1000, 15, 1'b0, 4, 1'b0, 4, 4'b0010);
        run_block("miss_z16",    32, 1000, 1000, 16, 1'b0, 4, 1'b0, 4, 4'b0000);
        state = 2'd0;
        run_block("t5_paused",   33, 1000, 1000, 10, 1'b0, 4, 1'b0, 2, 4'b0000);
        state = STATE_PLAYING;

        // Reset while a note is being checked; a valid prev would have sliced it.
        set_saber(1, 500, 300, 100, 500, 500, 100);
        pulse_hand();
        set_saber(1, 500, 380, 100, 500, 500, 100);
        @(negedge clk);
        bus.block_valid_in       = 1'b1;
        bus.block_index_in       = 8'd40;
        bus.block_x_in           = 500;
        bus.block_y_in           = 400;
        bus.block_z_in           = 100;
        bus.block_color_in       = 1'b1;
        bus.block_direction_in   = DIR_DOWN;
        bus.block_is_obstacle_in = 1'b0;
        @(posedge clk);
        #1 bus.block_valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_rst ready", 32'(bus.block_ready_out), 32'd1);
        check("t6_rst valid", 32'(bus.result_valid_out), 32'd0);
        check("t6_rst flags", 32'(flags()), 32'd0);
        @(negedge clk) rst = 1'b0;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.result_valid_out) stray++;
        end
        check("t6_no_verdict", 32'(stray), 32'd0);
        run_block("t6_prev_cleared", 41, 500, 400, 100, 1'b1, DIR_DOWN, 1'b0, 4, 4'b0100);
        run_block("t6_any",          42, 500, 400, 100, 1'b1, 4,        1'b0, 4, 4'b1000);
        pulse_hand();
        set_saber(1, 500, 460, 100, 500, 500, 100);
        run_block("t6_prev_back",    43, 500, 400, 100, 1'b1, DIR_DOWN, 1'b0, 4, 4'b1000);

        // Upward swing of 80: up slices, left does not.
        pulse_hand();
        set_saber(1, 500, 380, 100, 500, 500, 100);
        run_block("dir_up",          44, 500, 400, 100, 1'b1, DIR_UP,   1'b0, 4, 4'b1000);
        run_block("dir_left",        45, 500, 400, 100, 1'b1, DIR_LEFT, 1'b0, 4, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
